// File: rtl/bdd_pkg.sv
// Shared widths, node table entry layout and walker state encoding for the BDD node walker.
// Table entries are packed so a single write word carries a whole node.
package bdd_pkg;

   localparam int BDD_NODES       = 64;
   localparam int NODE_W          = 6;
   localparam int CLASS_W         = 4;
   localparam int ACC_W           = 20;
   localparam int BDD_MAX_DEPTH   = 16;
   localparam int BDD_ACC_TIMEOUT = 32;
   localparam int ENTRY_W         = 1 + CLASS_W + 2*NODE_W + ACC_W;

   typedef struct packed {
      logic               leaf;
      logic [CLASS_W-1:0] cls;
      logic [NODE_W-1:0]  left;
      logic [NODE_W-1:0]  right;
      logic [ACC_W-1:0]   threshold;
   } node_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } walk_state_t;

endpackage

// File: rtl/bdd_node_table.sv
// Node table: NODES entries, one synchronous write port, one combinational read port.
// Indices at or above NODES wrap back into the table; contents are never reset.
module bdd_node_table
   import bdd_pkg::*;
#(
   parameter int NODES = BDD_NODES
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [NODE_W-1:0]  i_waddr,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic [NODE_W-1:0]  i_raddr,
   output logic [ENTRY_W-1:0] o_rdata
);

   logic [ENTRY_W-1:0] r_mem [NODES];
   logic [NODE_W-1:0]  w_waddr;
   logic [NODE_W-1:0]  w_raddr;

   // NODE_W is clog2(NODES), so one subtraction is enough to fold any index back in range.
   function automatic logic [NODE_W-1:0] wrap_idx(input logic [NODE_W-1:0] idx);
      if ({1'b0, idx} >= (NODE_W+1)'(NODES))
         return idx - NODE_W'(NODES);
      return idx;
   endfunction

   assign w_waddr = wrap_idx(i_waddr);
   assign w_raddr = wrap_idx(i_raddr);

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[w_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[w_raddr];

endmodule

// File: rtl/bdd_node_walker.sv
// Decision-tree walker: requests MAC results per node, branches on threshold, reports leaf class.
// Optional path trace outputs when BDD_PATH_TRACE_EN is defined.
module bdd_node_walker
   import bdd_pkg::*;
#(
   parameter int NODES       = BDD_NODES,
   parameter int MAX_DEPTH   = BDD_MAX_DEPTH,
   parameter int ACC_TIMEOUT = BDD_ACC_TIMEOUT
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tbl_we,
   input  logic [NODE_W-1:0]    i_tbl_waddr,
   input  logic [ENTRY_W-1:0]   i_tbl_wdata,
   input  logic                 i_start,
   output logic [NODE_W-1:0]    o_node_idx,
   output logic                 o_coeff_req,
   input  logic [ACC_W-1:0]     i_acc,
   input  logic                 i_acc_valid,
   output logic [CLASS_W-1:0]   o_class_out,
   output logic                 o_class_valid,
   output logic                 o_busy,
`ifdef BDD_PATH_TRACE_EN
   output logic [MAX_DEPTH-1:0] o_path_bits,
   output logic [$clog2(MAX_DEPTH+1)-1:0] o_path_len,
`endif
   output logic                 o_walk_err
);

   localparam int DEPTH_W = $clog2(MAX_DEPTH+1);
   localparam int TMO_W   = $clog2(ACC_TIMEOUT);

   walk_state_t        r_state;
   walk_state_t        w_state_n;
   logic [NODE_W-1:0]  r_node_idx;
   logic [CLASS_W-1:0] r_class;
   logic [DEPTH_W-1:0] r_depth;
   logic [DEPTH_W-1:0] w_depth_n;
   logic [TMO_W-1:0]   r_tmo;
   logic [ENTRY_W-1:0] w_rdata;
   node_entry_t        w_entry;
   logic               w_busy;
   logic               w_tbl_we;
   logic               w_coeff_req;
   logic               w_class_valid;
   logic               w_walk_err;
   logic               w_go_right;
`ifdef BDD_PATH_TRACE_EN
   logic [MAX_DEPTH-1:0] r_path_bits;
   logic [DEPTH_W-1:0]   r_path_len;
`endif

   assign w_tbl_we = i_tbl_we & ~w_busy;

   bdd_node_table #(.NODES(NODES)) u_table (
      .i_clk   (i_clk),
      .i_we    (w_tbl_we),
      .i_waddr (i_tbl_waddr),
      .i_wdata (i_tbl_wdata),
      .i_raddr (r_node_idx),
      .o_rdata (w_rdata)
   );

   assign w_entry    = node_entry_t'(w_rdata);
   assign w_go_right = (i_acc >= w_entry.threshold);
   assign w_depth_n  = r_depth + DEPTH_W'(1);

   always_comb begin
      w_state_n     = r_state;
      w_coeff_req   = 1'b0;
      w_class_valid = 1'b0;
      w_walk_err    = 1'b0;
      w_busy        = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (i_start)
               w_state_n = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_entry.leaf) begin
               w_state_n = ST_DONE;
            end else begin
               w_coeff_req = 1'b1;
               w_state_n   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_acc_valid)
               w_state_n = (w_depth_n == DEPTH_W'(MAX_DEPTH)) ? ST_ERR : ST_ISSUE;
            else if (r_tmo == TMO_W'(ACC_TIMEOUT - 1))
               w_state_n = ST_ERR;
         end
         ST_DONE: begin
            w_class_valid = 1'b1;
            w_state_n     = ST_IDLE;
         end
         ST_ERR: begin
            w_walk_err = 1'b1;
            w_state_n  = ST_IDLE;
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_node_idx <= '0;
         r_class    <= '0;
         r_depth    <= '0;
         r_tmo      <= '0;
`ifdef BDD_PATH_TRACE_EN
         r_path_bits <= '0;
         r_path_len  <= '0;
`endif
      end else begin
         r_state <= w_state_n;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_node_idx <= '0;
                  r_depth    <= '0;
`ifdef BDD_PATH_TRACE_EN
                  r_path_bits <= '0;
                  r_path_len  <= '0;
`endif
               end
            end
            ST_ISSUE: begin
               if (w_entry.leaf)
                  r_class <= w_entry.cls;
               else
                  r_tmo <= '0;
            end
            ST_WAIT: begin
               if (i_acc_valid) begin
                  r_node_idx <= w_go_right ? w_entry.right : w_entry.left;
                  r_depth    <= w_depth_n;
`ifdef BDD_PATH_TRACE_EN
                  r_path_bits <= {r_path_bits[MAX_DEPTH-2:0], w_go_right};
                  r_path_len  <= r_path_len + DEPTH_W'(1);
`endif
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_node_idx    = r_node_idx;
   assign o_coeff_req   = w_coeff_req;
   assign o_class_out   = r_class;
   assign o_class_valid = w_class_valid;
   assign o_busy        = w_busy;
   assign o_walk_err    = w_walk_err;
`ifdef BDD_PATH_TRACE_EN
   assign o_path_bits   = r_path_bits;
   assign o_path_len    = r_path_len;
`endif

endmodule

// File: tb/tb_bdd_node_walker.sv
// Scoreboarded bench for bdd_node_walker: a software tree walk predicts class/error, latency and request count.
module tb_bdd_node_walker;
   import bdd_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tbl_we;
   logic [NODE_W-1:0]  tbl_waddr;
   logic [ENTRY_W-1:0] tbl_wdata;
   logic               start;
   logic [NODE_W-1:0]  node_idx;
   logic               coeff_req;
   logic [ACC_W-1:0]   acc;
   logic               acc_valid;
   logic [CLASS_W-1:0] class_out;
   logic               class_valid;
   logic               busy;
   logic               walk_err;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      bit                 err;
      logic [CLASS_W-1:0] cls;
      int                 lat;
      int                 nreq;
      logic [NODE_W-1:0]  idx;
   } exp_t;

   node_entry_t mdl_tbl [BDD_NODES];
   exp_t        sb [$];

   always #5 clk = ~clk;

   bdd_node_walker dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_tbl_we      (tbl_we),
      .i_tbl_waddr   (tbl_waddr),
      .i_tbl_wdata   (tbl_wdata),
      .i_start       (start),
      .o_node_idx    (node_idx),
      .o_coeff_req   (coeff_req),
      .i_acc         (acc),
      .i_acc_valid   (acc_valid),
      .o_class_out   (class_out),
      .o_class_valid (class_valid),
      .o_busy        (busy),
      .o_walk_err    (walk_err)
   );

   task automatic wr_entry(input int a, input bit leaf, input int cls, input int l, input int r, input int thr);
      node_entry_t e;
      e.leaf      = leaf;
      e.cls       = CLASS_W'(cls);
      e.left      = NODE_W'(l);
      e.right     = NODE_W'(r);
      e.threshold = ACC_W'(thr);
      @(negedge clk);
      tbl_we    = 1'b1;
      tbl_waddr = NODE_W'(a);
      tbl_wdata = e;
      @(negedge clk);
      tbl_we    = 1'b0;
      mdl_tbl[a] = e;
   endtask

   // Counts negedges after the start edge; ISSUE k sits at 1+k*(lat+1).
   function automatic exp_t model_walk(input logic [ACC_W-1:0] a, input int lat, input bit mac_en);
      exp_t        x;
      node_entry_t e;
      int          idx;
      int          d;
      x.err = 0; x.cls = '0; x.lat = 0; x.nreq = 0; x.idx = '0;
      idx = 0;
      d   = 0;
      for (int k = 0; k < 64; k++) begin
         e = mdl_tbl[idx];
         if (e.leaf) begin
            x.cls = e.cls;
            x.idx = NODE_W'(idx);
            x.lat = 2 + k*(lat+1);
            return x;
         end
         x.nreq++;
         if (!mac_en) begin
            x.err = 1;
            x.lat = 1 + k*(lat+1) + BDD_ACC_TIMEOUT + 1;
            return x;
         end
         d++;
         idx = (a >= e.threshold) ? int'(e.right) : int'(e.left);
         if (d == BDD_MAX_DEPTH) begin
            x.err = 1;
            x.lat = 1 + d*(lat+1);
            return x;
         end
      end
      return x;
   endfunction

   task automatic run_walk(input string name, input int a, input int lat, input bit mac_en, input bit disturb);
      int   cnt  = -1;
      int   c    = 0;
      int   nreq = 0;
      bit   done = 0;
      exp_t x;
      sb.push_back(model_walk(ACC_W'(a), lat, mac_en));
      @(negedge clk);
      start     = 1'b1;
      acc       = ACC_W'(a);
      acc_valid = disturb;
      while (!done && c < 300) begin
         @(negedge clk);
         c++;
         start     = 1'b0;
         tbl_we    = 1'b0;
         acc_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               acc_valid = 1'b1;
               cnt       = -1;
            end
         end
         if (coeff_req) begin
            nreq++;
            if (mac_en) cnt = lat;
         end
         if (class_valid || walk_err) begin
            done      = 1;
            acc_valid = 1'b0;
            x = sb.pop_front();
            n_chk++;
            if (walk_err !== x.err) begin
               n_fail++; $display("FAIL %s walk_err: got %0b want %0b", name, walk_err, x.err);
            end
            n_chk++;
            if (class_valid !== !x.err) begin
               n_fail++; $display("FAIL %s class_valid: got %0b want %0b", name, class_valid, !x.err);
            end
            n_chk++;
            if (c !== x.lat) begin
               n_fail++; $display("FAIL %s latency: got %0d want %0d", name, c, x.lat);
            end
            n_chk++;
            if (nreq !== x.nreq) begin
               n_fail++; $display("FAIL %s coeff_req count: got %0d want %0d", name, nreq, x.nreq);
            end
            if (!x.err) begin
               n_chk++;
               if (class_out !== x.cls) begin
                  n_fail++; $display("FAIL %s class_out: got %0d want %0d", name, class_out, x.cls);
               end
               n_chk++;
               if (node_idx !== x.idx) begin
                  n_fail++; $display("FAIL %s leaf node_idx: got %0d want %0d", name, node_idx, x.idx);
               end
            end
         end else if (disturb && c == 2) begin
            start     = 1'b1;
            tbl_we    = 1'b1;
            tbl_waddr = '0;
            tbl_wdata = '0;
         end
      end
      if (!done) begin
         void'(sb.pop_front());
         n_chk++; n_fail++;
         $display("FAIL %s completion: no class_valid/walk_err within %0d cycles", name, c);
      end
      @(negedge clk);
      n_chk++;
      if ({busy, class_valid, walk_err} !== 3'b000) begin
         n_fail++; $display("FAIL %s after pulse busy/cv/err: got %b want 000", name, {busy, class_valid, walk_err});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
      start = 1'b0; acc = '0; acc_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({busy, coeff_req, class_valid, walk_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset flags: got %b want 0000", {busy, coeff_req, class_valid, walk_err});
      end
      n_chk++;
      if (node_idx !== '0) begin
         n_fail++; $display("FAIL reset node_idx: got %0d want 0", node_idx);
      end
      n_chk++;
      if (class_out !== '0) begin
         n_fail++; $display("FAIL reset class_out: got %0d want 0", class_out);
      end
   endtask

   task automatic test_leaf_root();
      wr_entry(0, 1'b1, 5, 0, 0, 0);
      run_walk("leaf_root", 0, 1, 1'b1, 1'b0);
   endtask

   task automatic test_left_path();
      wr_entry(0, 1'b0, 0, 1, 2, 2000);
      wr_entry(1, 1'b1, 3, 0, 0, 0);
      wr_entry(2, 1'b1, 7, 0, 0, 0);
      run_walk("left_490", 490, 1, 1'b1, 1'b0);
   endtask

   task automatic test_right_equal();
      run_walk("right_eq_2000", 2000, 1, 1'b1, 1'b0);
      run_walk("left_470_stray_acc", 470, 3, 1'b1, 1'b1);
      run_walk("right_1999_miss", 1999, 2, 1'b1, 1'b0);
      run_walk("right_max", 20'hFFFFF, 1, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      run_walk("timeout", 3000, 1, 1'b0, 1'b0);
   endtask

   task automatic test_depth_abort();
      wr_entry(0, 1'b0, 0, 0, 0, 100);
      run_walk("depth_abort", 50, 1, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_walk();
      bit seen;
      wr_entry(0, 1'b0, 0, 1, 2, 2000);
      @(negedge clk); start = 1'b1; acc = ACC_W'(3000);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, coeff_req, class_valid, walk_err} !== 4'b0000) begin
         n_fail++; $display("FAIL midreset flags: got %b want 0000", {busy, coeff_req, class_valid, walk_err});
      end
      n_chk++;
      if (class_out !== '0) begin
         n_fail++; $display("FAIL midreset class_out: got %0d want 0", class_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < BDD_ACC_TIMEOUT + 8; i++) begin
         @(negedge clk);
         if (class_valid || walk_err || busy) seen = 1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL midreset stale activity: got %0b want 0", seen);
      end
      run_walk("post_reset_disturbed", 3000, 1, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      wr_entry(1, 1'b0, 0, 3, 4, 500);
      wr_entry(3, 1'b1, 9, 0, 0, 0);
      wr_entry(4, 1'b1, 12, 0, 0, 0);
      run_walk("b2b_a", 499, 1, 1'b1, 1'b0);
      run_walk("b2b_b", 500, 2, 1'b1, 1'b0);
      run_walk("b2b_c", 2500, 1, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_leaf_root();
      test_left_path();
      test_right_equal();
      test_timeout();
      test_depth_abort();
      test_reset_mid_walk();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
